hash_sequencer: RTL and testbench

HASH_SEQUENCER -- requirements
Module: hash_sequencer

---
 rtl/hash_sequencer.sv | 141 ++++++++++++++
 tb/tb_hash_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hash_sequencer.sv
// Nonce-sweep sequencer for a double-SHA-256 core: steps three compression chunks per nonce
// (midstate chunk C1 only once), checks the target, and walks the nonce range until hit or exhaustion.
module hash_sequencer #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] nonce_first,
    input  logic [31:0] nonce_last,
    input  logic        hit,
    output logic [1:0]  Block,
    output logic        nonce_sig,
    output logic [5:0]  round,
    output logic [31:0] nonce,
    output logic        busy,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic        exhausted,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_C1    = 3'd2,
        S_C2    = 3'd3,
        S_C3    = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t      state_q;
    logic [1:0]  block_q;
    logic        sig_q;
    logic [5:0]  round_q;
    logic [31:0] nonce_q;
    logic [31:0] limit_q;
    logic        busy_q;
    logic        found_q;
    logic        exh_q;
    logic [31:0] found_nonce_q;

    logic chunk_last;
    logic abort;

    assign chunk_last = (round_q == LAST_ROUND);
    assign abort      = stop && (state_q inside {S_INIT, S_C1, S_C2, S_C3, S_CHECK});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            block_q       <= 2'd0;
            sig_q         <= 1'b0;
            round_q       <= 6'd0;
            nonce_q       <= 32'd0;
            limit_q       <= 32'd0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exh_q         <= 1'b0;
            found_nonce_q <= 32'd0;
        end else if (abort) begin
            // Abort wins over everything, including a hit in the same CHECK cycle.
            state_q <= S_IDLE;
            block_q <= 2'd0;
            sig_q   <= 1'b0;
            round_q <= 6'd0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_INIT;
                        nonce_q <= nonce_first;
                        limit_q <= nonce_last;
                        block_q <= 2'd0;
                        sig_q   <= 1'b0;
                        round_q <= 6'd0;
                        busy_q  <= 1'b1;
                        found_q <= 1'b0;
                        exh_q   <= 1'b0;
                    end
                end
                S_INIT: begin
                    state_q <= S_C1;
                    round_q <= 6'd0;
                end
                S_C1, S_C2, S_C3: begin
                    if (chunk_last) begin
                        round_q <= 6'd0;
                        case (state_q)
                            S_C1:    begin state_q <= S_C2;    block_q <= 2'd1; end
                            S_C2:    begin state_q <= S_C3;    block_q <= 2'd2; end
                            default: begin state_q <= S_CHECK; block_q <= 2'd3; end
                        endcase
                    end else begin
                        round_q <= round_q + 6'd1;
                    end
                end
                S_CHECK: begin
                    round_q <= 6'd0;
                    if (hit) begin
                        state_q       <= S_DONE;
                        busy_q        <= 1'b0;
                        found_q       <= 1'b1;
                        found_nonce_q <= nonce_q;
                    end else if (nonce_q == limit_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        exh_q   <= 1'b1;
                    end else begin
                        // Midstate is reused: later nonces skip C1; Block stays 3 through this C2.
                        state_q <= S_C2;
                        nonce_q <= nonce_q + 32'd1;
                        sig_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Block       = block_q;
    assign nonce_sig   = sig_q;
    assign round       = round_q;
    assign nonce       = nonce_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign exhausted   = exh_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_hash_sequencer.sv
// Directed bench for hash_sequencer: table of whole sweeps with a per-cycle trace model,
// plus hand-written sequences for stop, async reset and start held through DONE.
module tb_hash_sequencer;

    localparam int R = 64;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_INIT = 3'd1, ST_C1 = 3'd2, ST_C2 = 3'd3,
                           ST_C3 = 3'd4, ST_CHECK = 3'd5, ST_DONE = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] nonce_first = '0;
    logic [31:0] nonce_last = '0;
    logic        hit = 1'b0;
    logic [1:0]  block;
    logic        nonce_sig;
    logic [5:0]  round_w;
    logic [31:0] nonce;
    logic        busy;
    logic        found;
    logic [31:0] found_nonce;
    logic        exhausted;
    logic [2:0]  state_dbg;

    int n_pass = 0;
    int n_total = 0;

    hash_sequencer #(.ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .hit(hit),
        .Block(block), .nonce_sig(nonce_sig), .round(round_w), .nonce(nonce),
        .busy(busy), .found(found), .found_nonce(found_nonce), .exhausted(exhausted),
        .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] first;
        logic [31:0] last;
        int          hit_at;      // which CHECK (1-based) sees hit=1; 0 = never
        logic        exp_found;
        logic        exp_exh;
        logic [31:0] exp_nonce;
        logic [31:0] exp_fn;
        logic        exp_sig;
        int          exp_checks;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_for(input logic [2:0] st, input logic [5:0] rnd, input string name);
        int n = 0;
        while (!(state_dbg == st && round_w == rnd) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int c = 0, checks = 0, busy_cyc = 0, c1_ent = 0, trace_err = 0;
        int o2, j, o;
        logic [2:0] e_st, prev_st;
        logic [1:0] e_blk;
        logic [5:0] e_rnd;
        logic done = 1'b0;
        string tag;
        tag = $sformatf("v%0d", idx);
        start = 1'b1; nonce_first = v.first; nonce_last = v.last;
        prev_st = state_dbg;
        step();
        start = 1'b0;
        while (!done && c < 20000) begin
            if (state_dbg == ST_DONE) begin
                done = 1'b1;
            end else begin
                if (c == 0) begin
                    e_st = ST_INIT; e_blk = 2'd0; e_rnd = 6'd0; j = 0;
                end else if (c <= R) begin
                    e_st = ST_C1; e_blk = 2'd0; e_rnd = 6'(c - 1); j = 0;
                end else begin
                    o2 = c - (R + 1);
                    j  = o2 / (2 * R + 1);
                    o  = o2 % (2 * R + 1);
                    if (o < R) begin
                        e_st = ST_C2; e_blk = (j == 0) ? 2'd1 : 2'd3; e_rnd = 6'(o);
                    end else if (o < 2 * R) begin
                        e_st = ST_C3; e_blk = 2'd2; e_rnd = 6'(o - R);
                    end else begin
                        e_st = ST_CHECK; e_blk = 2'd3; e_rnd = 6'd0;
                    end
                end
                if (state_dbg !== e_st || block !== e_blk || round_w !== e_rnd ||
                    nonce_sig !== (j > 0) || nonce !== v.first + 32'(j) || busy !== 1'b1 ||
                    (found && exhausted))
                    trace_err++;
                if (state_dbg == ST_C1 && prev_st != ST_C1) c1_ent++;
                busy_cyc += int'(busy);
                if (state_dbg == ST_CHECK) checks++;
                hit = (state_dbg == ST_CHECK) && (checks == v.hit_at);
                prev_st = state_dbg;
                step();
                hit = 1'b0;
                c++;
            end
        end
        chk({tag, "_reached_done"}, 32'(done), 32'd1);
        chk({tag, "_trace_errors"}, 32'(trace_err), 32'd0);
        chk({tag, "_c1_entries"}, 32'(c1_ent), 32'd1);
        chk({tag, "_checks"}, 32'(checks), 32'(v.exp_checks));
        chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(1 + R + v.exp_checks * (2 * R + 1)));
        chk({tag, "_found"}, 32'(found), 32'(v.exp_found));
        chk({tag, "_exhausted"}, 32'(exhausted), 32'(v.exp_exh));
        chk({tag, "_nonce"}, nonce, v.exp_nonce);
        chk({tag, "_nonce_sig"}, 32'(nonce_sig), 32'(v.exp_sig));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (v.exp_found) chk({tag, "_found_nonce"}, found_nonce, v.exp_fn);
        step();
        chk({tag, "_done_holds"}, {29'd0, state_dbg}, {29'd0, ST_DONE});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
        chk({tag, "_outs"}, {22'd0, block, nonce_sig, round_w, busy, found, exhausted},
            32'd0);
        chk({tag, "_nonce"}, nonce, 32'd0);
        chk({tag, "_found_nonce"}, found_nonce, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'd5, 32'd5, 0, 1'b0, 1'b1, 32'd5, 32'd0, 1'b0, 1};
        vecs[1] = '{32'd10, 32'd12, 2, 1'b1, 1'b0, 32'd11, 32'd11, 1'b1, 2};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b1, 32'd1, 32'd0, 1'b1, 3};
        vecs[3] = '{32'd100, 32'd103, 1, 1'b1, 1'b0, 32'd100, 32'd100, 1'b0, 1};
        vecs[4] = '{32'd7, 32'd9, 0, 1'b0, 1'b1, 32'd9, 32'd0, 1'b1, 3};

        #3;
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();
        chk("idle_stays", {29'd0, state_dbg}, {29'd0, ST_IDLE});

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Stop at round 30 of C3 while hit is asserted.
        start = 1'b1; nonce_first = 32'd40; nonce_last = 32'd41;
        step();
        start = 1'b0;
        wait_for(ST_C3, 6'd30, "stop_c3");
        stop = 1'b1; hit = 1'b1;
        step();
        stop = 1'b0; hit = 1'b0;
        chk("stop_c3_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        chk("stop_c3_flags", {29'd0, found, exhausted, busy}, 32'd0);
        chk("stop_c3_block", 32'(block), 32'd0);

        // Stop beats hit in the CHECK cycle.
        start = 1'b1; nonce_first = 32'd50; nonce_last = 32'd50;
        step();
        start = 1'b0;
        wait_for(ST_CHECK, 6'd0, "stop_chk");
        stop = 1'b1; hit = 1'b1;
        step();
        stop = 1'b0; hit = 1'b0;
        chk("stop_chk_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        chk("stop_chk_found", 32'(found), 32'd0);

        // Asynchronous reset mid-C2, then a normal sweep.
        start = 1'b1; nonce_first = 32'd60; nonce_last = 32'd62;
        step();
        start = 1'b0;
        wait_for(ST_C2, 6'd10, "arst");
        #2 rst = 1'b1;
        #1 chk_reset_outputs("arst");
        #1 rst = 1'b0;
        step();
        chk("arst_idle", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        run_vec(5, vecs[0]);

        // start held high throughout: restarts straight out of DONE.
        start = 1'b1; nonce_first = 32'd20; nonce_last = 32'd20;
        step();
        nonce_first = 32'd30; nonce_last = 32'd30;
        wait_for(ST_DONE, 6'd0, "hold");
        chk("hold_exh", 32'(exhausted), 32'd1);
        chk("hold_nonce", nonce, 32'd20);
        step();
        chk("hold_init", {29'd0, state_dbg}, {29'd0, ST_INIT});
        chk("hold_cleared", {30'd0, found, exhausted}, 32'd0);
        chk("hold_new_nonce", nonce, 32'd30);
        start = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("hold_stopped", {29'd0, state_dbg}, {29'd0, ST_IDLE});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
